mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Encodes instruction descriptors (mnemonic code plus register/immediate fields) into 32-bit MIPS machine words for the same instruction set the single-cycle controller decodes. Each word is streamed out with a sequential word address to the instruction-memory loader. It sits in the bench/boot path ahead of IM, and its output must round-trip through the controller's decode.

## Interface
- `BASE_ADDR`, default 32'h0000_3000: address of the first emitted word.
- `DEPTH`, default 1024: maximum number of words emitted before the block reports full.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: reset; asynchronous, active-low.
- `clear` input 1: synchronous restart; same effect as reset, takes priority over every other input.
- `in_valid` input 1: descriptor present.
- `in_ready` output 1: descriptor accepted when `in_valid && in_ready` at the rising edge.
- `in_mnem` input 5: mnemonic code: 0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 sll, 8 jal, 9 jr, 10 bgez, 11 lb, 12 sb, 13 j, 14 sltu, 15 slt, 16 addi; all other codes are illegal.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` input 5 each: register and shift-amount fields.
- `in_imm` input 26: I-type instructions use [15:0]; J-type instructions use all 26 bits as the word target.
- `out_valid` output 1: encoded word available.
- `out_ready` input 1: consumer takes the word when `out_valid && out_ready`.
- `out_instr` output 32: encoded word.
- `out_addr` output 32: byte address of `out_instr`.
- `full` output 1: DEPTH legal words have been accepted.
- `err_illegal` output 1: sticky flag; set by an accepted illegal descriptor, cleared only by reset or clear.
- `err_count` output 8: number of illegal descriptors accepted; saturates at 255.

## Operation
- R-type words have op=0 and fields {rs,rt,rd,shamt,fc}:
  - addu fc 0x21, subu 0x23, sltu 0x2B, slt 0x2A: shamt forced to 0.
  - sll fc 0x00: rs forced to 0.
  - jr fc 0x08: rt, rd and shamt forced to 0.
- I-type words are {op,rs,rt,imm[15:0]}:
  - ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lb 0x20, sb 0x28, addi 0x08.
  - lui 0x0F: rs forced to 0.
  - bgez op 0x01: rt forced to 5'b00001, whatever the input.
- J-type words are {op,imm[25:0]}: jal 0x03, j 0x02.
- Unused descriptor fields are ignored; no bits leak into the forced-zero fields.
- Legal accepted descriptors are pushed into a 2-entry output FIFO together with their address.
- Address counter `wr_addr` starts at BASE_ADDR and advances by 4 per legal accept. `out_addr` is the address captured at push.
- Illegal accepted descriptors are consumed but produce no FIFO push and no address advance. They set `err_illegal` and increment `err_count`.
- `in_ready` = (FIFO occupancy < 2) && !full. There is no combinational path from `out_ready` to `in_ready`.
- `full` asserts once `accepted == DEPTH` (accepted is a 32-bit internal counter, width ≥ clog2(DEPTH)+1). It stays asserted until reset or clear; the FIFO still drains while full.
- `out_valid`, `out_instr` and `out_addr` are held stable while `out_valid && !out_ready`.

## Timing
- Reset or clear: `in_ready`=1, `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `full`=0, `err_illegal`=0, `err_count`=0, FIFO empty, `wr_addr`=BASE_ADDR.
- Latency: a descriptor accepted at edge N appears on `out_valid`/`out_instr` after edge N (registered FIFO head). With `out_ready` tied high, throughput is 1 word per cycle.
- A push and a pop at the same edge leave occupancy unchanged; the head advances and the tail is written.
- With 2 entries occupied, `in_ready`=0 in that cycle. Only a pop frees a slot, and `in_ready` rises the following cycle.
- At the edge where the DEPTH-th legal word is accepted, `full` rises and `in_ready` falls for the next cycle.
- An illegal descriptor accepted while `full`=0 is still counted; none can be accepted while full.
- Reset asserted mid-stream discards FIFO contents immediately, without waiting for a clock edge.

## Configuration
- `MIPS_ENC_EXT_EN` defined: all 17 mnemonics are legal.
- Undefined: only codes 0–9 (addu through jr) are legal. Codes 10–16 are treated as illegal: they are consumed, flagged and counted, with no word emitted.

## Test plan
- Reset, then stream addu rs=1 rt=2 rd=3, ori rs=0 rt=4 imm=0x1234, with `out_ready`=1 -> words 0x00221821 @0x3000 and 0x34041234 @0x3004, one cycle after each accept.
- bgez rs=5 rt=0 imm=0xFFFE and lui rs=7 rt=8 imm=0xABCD (EXT_EN) -> 0x04A1FFFE and 0x3C08ABCD. Check the forced rt and the forced rs.
- Hold `out_ready`=0 and offer 3 descriptors -> 2 accepted, `in_ready`=0, head stable. Release `out_ready` -> all 3 emitted in order at consecutive addresses.
- in_mnem=20, then j imm=0x0000C00 -> `err_illegal`=1, `err_count`=1; j emitted as 0x08000C00 @0x3000.
- DEPTH=4: send 5 legal descriptors -> 4 words (0x3000..0x300C), then `full`=1 and `in_ready`=0. Assert clear -> `full`=0, next word @0x3000.
- Without MIPS_ENC_EXT_EN: slt -> no word emitted, `err_count` increments. Assert reset mid-burst -> `out_valid`=0 asynchronously.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Encodes MIPS instruction descriptors into 32-bit words streamed with sequential byte addresses.
// Build option: define MIPS_ENC_EXT_EN to make mnemonic codes 10..16 legal (default: only 0..9).
module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [25:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        full,
  output logic        err_illegal,
  output logic [7:0]  err_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  localparam logic [31:0] LAST_IDX = 32'(DEPTH - 1);
  localparam entry_t      RST_ENTRY = '{instr: 32'd0, addr: BASE_ADDR};

  entry_t [1:0] fifoMem;
  logic         rdPtr, wrPtr;
  logic [1:0]   count;
  logic [31:0]  wrAddr, accepted;
  logic         legal;
  logic [31:0]  encWord;
  logic         accept, push, pop;

  always_comb begin
    legal   = 1'b1;
    encWord = '0;
    case (in_mnem)
      5'd0:  encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      5'd1:  encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      5'd2:  encWord = {6'h0D, in_rs, in_rt, in_imm[15:0]};
      5'd3:  encWord = {6'h23, in_rs, in_rt, in_imm[15:0]};
      5'd4:  encWord = {6'h2B, in_rs, in_rt, in_imm[15:0]};
      5'd5:  encWord = {6'h04, in_rs, in_rt, in_imm[15:0]};
      5'd6:  encWord = {6'h0F, 5'd0, in_rt, in_imm[15:0]};
      5'd7:  encWord = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
      5'd8:  encWord = {6'h03, in_imm};
      5'd9:  encWord = {6'h00, in_rs, 15'd0, 6'h08};
`ifdef MIPS_ENC_EXT_EN
      // bgez is REGIMM: the rt slot carries the sub-opcode, not a register
      5'd10: encWord = {6'h01, in_rs, 5'b00001, in_imm[15:0]};
      5'd11: encWord = {6'h20, in_rs, in_rt, in_imm[15:0]};
      5'd12: encWord = {6'h28, in_rs, in_rt, in_imm[15:0]};
      5'd13: encWord = {6'h02, in_imm};
      5'd14: encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2B};
      5'd15: encWord = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      5'd16: encWord = {6'h08, in_rs, in_rt, in_imm[15:0]};
`endif
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = (count != 2'd2) && !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = fifoMem[rdPtr].instr;
  assign out_addr  = fifoMem[rdPtr].addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifoMem <= {RST_ENTRY, RST_ENTRY};
      rdPtr   <= 1'b0;
      wrPtr   <= 1'b0;
      count   <= 2'd0;
    end else if (clear) begin
      fifoMem <= {RST_ENTRY, RST_ENTRY};
      rdPtr   <= 1'b0;
      wrPtr   <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= '{instr: encWord, addr: wrAddr};
        wrPtr          <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Address/accept bookkeeping only moves on legal words; illegal ones just bump the error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrAddr      <= BASE_ADDR;
      accepted    <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else if (clear) begin
      wrAddr      <= BASE_ADDR;
      accepted    <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      if (push) begin
        wrAddr   <= wrAddr + 32'd4;
        accepted <= accepted + 32'd1;
        if (accepted == LAST_IDX) full <= 1'b1;
      end
      if (accept && !legal) begin
        err_illegal <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: driver queues expected words, monitor pops on output handshakes.
module tb_mips_instr_encoder;

`ifdef MIPS_ENC_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0, reset = 1'b0, clear = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [4:0]  in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [25:0] in_imm = '0;
  logic [31:0] out_instr, out_addr;
  logic        full, err_illegal;
  logic [7:0]  err_count;

  mips_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .full(full), .err_illegal(err_illegal), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] addr; } exp_t;
  exp_t        sb[$];
  exp_t        monE;
  int          errors = 0, checks = 0;
  logic [31:0] tbAddr = BASE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected word
  always @(negedge clk) begin
    if (reset && !clear && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h @%h expected none", out_instr, out_addr);
      end else begin
        monE = sb.pop_front();
        if (out_instr !== monE.instr || out_addr !== monE.addr) begin
          errors++;
          $display("FAIL word: got %h @%h expected %h @%h", out_instr, out_addr, monE.instr, monE.addr);
        end
      end
    end
  end

  task automatic send(input logic [4:0] m, rs, rt, rd, sh, input logic [25:0] imm,
                      input bit legal, input logic [31:0] exp);
    bit done = 0;
    in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (legal) begin
          sb.push_back('{instr: exp, addr: tbAddr});
          tbAddr += 32'd4;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept of mnem %0d", m);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic doClear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    sb.delete();
    tbAddr = BASE;
  endtask

  initial begin
    logic [31:0] held;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err_illegal", 32'(err_illegal), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Basic stream, one-cycle latency
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1, 32'h0022_1821);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_instr", out_instr, 32'h0022_1821);
    send(5'd2, 5'd0, 5'd4, 5'd0, 5'd0, 26'h1234, 1, 32'h3404_1234);
    check("lat_addr", out_addr, 32'h0000_3004);
    drain();

    // bgez forced rt (illegal in default build), lui forced rs
    doClear();
    send(5'd10, 5'd5, 5'd0, 5'd0, 5'd0, 26'h0FFFE, EXT, 32'h04A1_FFFE);
    send(5'd6, 5'd7, 5'd8, 5'd0, 5'd0, 26'h0ABCD, 1, 32'h3C08_ABCD);
    check("bgez_err_count", 32'(err_count), EXT ? 32'd0 : 32'd1);
    drain();

    // Backpressure: 2 accepted, third stalls until out_ready returns
    doClear();
    out_ready = 1'b0;
    send(5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 26'd0, 1, 32'h0085_3023);
    send(5'd7, 5'd9, 5'd2, 5'd3, 5'd4, 26'd0, 1, 32'h0002_1900);
    fork
      send(5'd9, 5'd31, 5'd1, 5'd2, 5'd3, 26'd0, 1, 32'h03E0_0008);
      begin
        @(negedge clk); held = out_instr;
        repeat (3) @(negedge clk);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_instr", out_instr, held);
        check("hold_head", out_instr, 32'h0085_3023);
        check("hold_addr", out_addr, BASE);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Illegal code, then j at the base address; slt depends on build
    doClear();
    send(5'd20, 5'd1, 5'd1, 5'd1, 5'd1, 26'h3FF_FFFF, 0, 32'd0);
    check("ill_flag", 32'(err_illegal), 32'd1);
    check("ill_count", 32'(err_count), 32'd1);
    send(5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 26'h000_0C00, EXT, 32'h0800_0C00);
    send(5'd15, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, EXT, 32'h0022_182A);
    check("slt_count", 32'(err_count), EXT ? 32'd1 : 32'd3);
    drain();

    // DEPTH=4 fills, fifth is refused, clear restarts at base
    doClear();
    send(5'd3, 5'd29, 5'd8, 5'd0, 5'd0, 26'h0004, 1, 32'h8FA8_0004);
    send(5'd4, 5'd29, 5'd9, 5'd0, 5'd0, 26'h0008, 1, 32'hAFA9_0008);
    send(5'd5, 5'd1, 5'd2, 5'd0, 5'd0, 26'hFFFF, 1, 32'h1022_FFFF);
    check("pre_full", 32'(full), 32'd0);
    send(5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFF, 1, 32'h0FFF_FFFF);
    check("full_set", 32'(full), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_mnem = 5'd0;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("full_stays", 32'(full), 32'd1);
    check("full_refuse_rdy", 32'(in_ready), 32'd0);
    drain();
    doClear();
    check("clr_full", 32'(full), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    check("clr_err_count", 32'(err_count), 32'd0);
    send(5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 26'h00FF, 1, 32'h3464_00FF);
    check("clr_addr", out_addr, BASE);
    drain();

    // Asynchronous reset mid-burst
    out_ready = 1'b0;
    send(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, 1, 32'h0021_0821);
    send(5'd0, 5'd2, 5'd2, 5'd2, 5'd0, 26'd0, 1, 32'h0042_1021);
    #2 reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_addr", out_addr, BASE);
    sb.delete();
    tbAddr = BASE;
    out_ready = 1'b1;
    #9 reset = 1'b1;
    @(posedge clk); #1;
    send(5'd9, 5'd31, 5'd0, 5'd0, 5'd0, 26'd0, 1, 32'h03E0_0008);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
